// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
// The initiator drives the master side; the responder is the slave side.
interface mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o, busy_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o, busy_o
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory slave with grant stall, bounded outstanding
// requests and a fixed-latency response pipeline.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned GNT_WAIT    = 0,
    parameter int unsigned RSP_LAT     = 1,
    parameter int unsigned MAX_OUT     = 2
) (
    input logic           clk_i,
    input logic           rst_ni,
    mem_responder_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_MAX = 4'(GNT_WAIT);
    localparam logic [3:0]  OUT_MAX  = 4'(MAX_OUT);

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [3:0]         r_wait;
    logic [3:0]         r_out;
    logic [RSP_LAT-1:0] r_pv;
    logic [RSP_LAT-1:0] r_pe;
    logic [31:0]        r_pd [RSP_LAT];

    logic [31:0]   w_off;
    logic [31:0]   w_mask;
    logic [31:0]   w_rdata;
    logic [AW-1:0] w_idx;
    logic          w_ok;
    logic          w_gnt;
    logic          w_rsp;

    // Offset compare is done in 33 bits so the top of the window cannot wrap.
    assign w_off = bus.addr_i - BASE_ADDR;
    assign w_ok  = (bus.addr_i >= BASE_ADDR)
                && ({1'b0, w_off} < SPAN)
                && (bus.addr_i[1:0] == 2'b00);
    assign w_idx = w_off[AW+1:2];

    assign w_mask = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}},
                     {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};

    assign w_gnt = rst_ni && bus.req_i
                && (r_wait == WAIT_MAX)
                && (r_out < OUT_MAX);

    assign w_rsp   = r_pv[RSP_LAT-1];
    assign w_rdata = (w_ok && !bus.we_i) ? (r_mem[w_idx] & w_mask) : '0;

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_pv[RSP_LAT-1];
    assign bus.err_o    = r_pe[RSP_LAT-1];
    assign bus.rdata_o  = r_pd[RSP_LAT-1];
    assign bus.busy_o   = (r_out != 4'd0);

    always_ff @(posedge clk_i) begin
        if (w_gnt && w_ok && bus.we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= 4'd0;
            r_out  <= 4'd0;
            r_pv   <= '0;
            r_pe   <= '0;
            for (int i = 0; i < RSP_LAT; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            if (!bus.req_i || w_gnt) begin
                r_wait <= 4'd0;
            end else if (r_wait < WAIT_MAX) begin
                r_wait <= r_wait + 4'd1;
            end

            unique case ({w_gnt, w_rsp})
                2'b10:   r_out <= r_out + 4'd1;
                2'b01:   r_out <= r_out - 4'd1;
                default: r_out <= r_out;
            endcase

            // Idle stages carry zeros so err/rdata stay low without rvalid.
            r_pv[0] <= w_gnt;
            r_pe[0] <= w_gnt && !w_ok;
            r_pd[0] <= w_gnt ? w_rdata : '0;
            for (int i = 1; i < RSP_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: default instance scoreboarded, plus stall and
// outstanding-limit instances checked cycle by cycle.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_w = 1'b0;
    logic rst_m = 1'b0;
    int   cyc = 0;
    int   npass = 0;
    int   nfail = 0;
    int   ntot = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_responder_if d ();
    mem_responder_if w ();
    mem_responder_if m ();

    mem_responder u_d (
        .clk_i (clk),
        .rst_ni(rst_d),
        .bus   (d)
    );

    mem_responder #(
        .GNT_WAIT(3),
        .RSP_LAT (4)
    ) u_w (
        .clk_i (clk),
        .rst_ni(rst_w),
        .bus   (w)
    );

    mem_responder #(
        .MAX_OUT(2),
        .RSP_LAT(4)
    ) u_m (
        .clk_i (clk),
        .rst_ni(rst_m),
        .bus   (m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (d.rvalid_o) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rvalid", d.rvalid_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_latency", cyc, e.cyc);
                    chk("sb_err", d.err_o, e.err);
                    chk("sb_rdata", d.rdata_o, e.data);
                end
            end else begin
                chk("idle_outputs_zero", {d.err_o, d.rdata_o}, 33'h0);
            end
        end
    end

    task automatic xact(input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_data);
        d.req_i   = 1'b1;
        d.we_i    = we;
        d.be_i    = be;
        d.addr_i  = addr;
        d.wdata_i = wd;
        @(negedge clk);
        chk($sformatf("d_gnt_%h", addr), d.gnt_o, 1'b1);
        sb.push_back('{cyc + 1, e_err, e_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        d.req_i = 1'b1; d.we_i = 1'b0; d.be_i = 4'hF;
        d.addr_i = '0;  d.wdata_i = '0;
        w.req_i = 1'b0; w.we_i = 1'b0; w.be_i = 4'hF;
        w.addr_i = '0;  w.wdata_i = '0;
        m.req_i = 1'b0; m.we_i = 1'b0; m.be_i = 4'hF;
        m.addr_i = '0;  m.wdata_i = '0;
        #1;
        chk("rst_gnt", d.gnt_o, 1'b0);
        chk("rst_rvalid", d.rvalid_o, 1'b0);
        chk("rst_err_rdata", {d.err_o, d.rdata_o}, 33'h0);
        chk("rst_busy", d.busy_o, 1'b0);
        d.req_i = 1'b0;

        @(posedge clk);
        #1;
        rst_d = 1'b1; rst_w = 1'b1; rst_m = 1'b1;
        mon_en = 1'b1;

        xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        xact(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'h0);
        xact(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 1'b0, 32'h0);
        xact(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h11BB33DD);
        xact(1'b0, 4'h3, 32'h20, 32'h0, 1'b0, 32'h000033DD);
        xact(1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, 32'h0);
        xact(1'b0, 4'hF, 32'h2, 32'h0, 1'b1, 32'h0);
        xact(1'b1, 4'hF, 32'hFFC, 32'h12345678, 1'b0, 32'h0);
        xact(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
        xact(1'b0, 4'hF, 32'hFFC, 32'h0, 1'b0, 32'h12345678);
        xact(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 32'h0);
        xact(1'b1, 4'hF, 32'h12, 32'h0, 1'b1, 32'h0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        d.req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_busy_idle", d.busy_o, 1'b0);
        chk("sb_drained", sb.size(), 0);

        // Stall instance: the values present during the stall are ignored.
        @(posedge clk);
        #1;
        w.req_i = 1'b1; w.we_i = 1'b0; w.addr_i = 32'h2;
        for (int c = 0; c <= 8; c++) begin
            if (c == 3) begin
                w.we_i = 1'b1; w.addr_i = 32'h0; w.wdata_i = 32'h5A5A5A5A;
            end
            @(negedge clk);
            chk($sformatf("w1_gnt_c%0d", c), w.gnt_o, 64'(c == 3));
            chk($sformatf("w1_rvalid_c%0d", c), w.rvalid_o, 64'(c == 7));
            if (c == 7) chk("w1_rsp", {w.err_o, w.rdata_o}, 33'h0);
            @(posedge clk);
            #1;
            if (c == 3) w.req_i = 1'b0;
        end

        w.we_i = 1'b0; w.addr_i = 32'h1000;
        for (int c = 0; c <= 10; c++) begin
            w.req_i = (c != 2) && (c < 7);
            @(negedge clk);
            chk($sformatf("w2_gnt_c%0d", c), w.gnt_o, 64'(c == 6));
            chk($sformatf("w2_rvalid_c%0d", c), w.rvalid_o, 64'(c == 10));
            if (c == 10) chk("w2_rsp", {w.err_o, w.rdata_o}, {1'b1, 32'h0});
            @(posedge clk);
            #1;
        end

        // Outstanding limit: two grants, then stall until the first response.
        m.we_i = 1'b1; m.addr_i = 32'h40; m.wdata_i = 32'hCAFEF00D;
        for (int c = 0; c <= 10; c++) begin
            m.req_i = (c < 6);
            @(negedge clk);
            chk($sformatf("m_gnt_c%0d", c), m.gnt_o,
                64'((c < 2) || (c == 5)));
            chk($sformatf("m_rvalid_c%0d", c), m.rvalid_o,
                64'((c == 4) || (c == 5) || (c == 9)));
            if (c >= 1) chk($sformatf("m_busy_c%0d", c), m.busy_o, 64'(c <= 9));
            @(posedge clk);
            #1;
        end

        m.we_i = 1'b0; m.req_i = 1'b1;
        for (int c = 0; c <= 1; c++) begin
            @(negedge clk);
            chk($sformatf("mr_gnt_c%0d", c), m.gnt_o, 1'b1);
            @(posedge clk);
            #1;
        end
        m.req_i = 1'b1;
        #2;
        rst_m = 1'b0;
        #1;
        chk("mr_rst_gnt", m.gnt_o, 1'b0);
        chk("mr_rst_rvalid", m.rvalid_o, 1'b0);
        chk("mr_rst_busy", m.busy_o, 1'b0);
        m.req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_m = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("mr_no_rvalid_c%0d", c), m.rvalid_o, 1'b0);
            chk($sformatf("mr_busy_c%0d", c), m.busy_o, 1'b0);
        end
        @(posedge clk);
        #1;
        m.req_i = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) chk("mr_read_gnt", m.gnt_o, 1'b1);
            chk($sformatf("mr_read_rvalid_c%0d", c), m.rvalid_o, 64'(c == 4));
            if (c == 4) chk("mr_retained", {m.err_o, m.rdata_o},
                            {1'b0, 32'hCAFEF00D});
            @(posedge clk);
            #1;
            m.req_i = 1'b0;
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
